uart_rx: RTL and testbench

//  Serial UART receiver, 8N1 by default. Consumes the OVERSAMPLE x baud tick from baud_gen
//  (baud_rate_rx) and recovers bytes from the rx pin. Centre-samples each bit and validates

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and defaults, used by both the RX and TX paths.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser; both flops reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-samples an oversampled rx line, checks start/stop bits
// and presents each byte on a valid/ready port.
import uart_pkg::*;

module uart_rx #(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy,
    output uart_rx_state_t       state
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    // Idle level is high so a reset never looks like a start bit.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    assign busy = (state != IDLE);

    // Output handshake: a byte transfers on any posedge where rx_valid && rx_ready;
    // rx_data is held stable while rx_valid is high, and rx_valid stays up until taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_cnt == HALF_TICK) begin
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                                // A slot is free if empty or being emptied this very cycle.
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun_err <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are serialised on rx at the line
// rate, expected bytes queued at send time, and a monitor pops on each handshake.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW        = 8;
    localparam int OS        = 16;
    localparam int TICK_CLKS = 8;
    localparam int BIT_CLKS  = TICK_CLKS * OS;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           baud_tick = 1'b0;
    logic           rx = 1'b1;
    logic           rx_ready = 1'b0;
    logic [DW-1:0]  rx_data;
    logic           rx_valid;
    logic           frame_err;
    logic           overrun_err;
    logic           busy;
    uart_rx_state_t state;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rx_cnt = 0;
    int vcyc = 0;
    int n_sent = 0;
    int rdy_mode = 0;
    int tick_div = 0;
    logic [DW-1:0] exp_q[$];

    uart_rx #(.DATA_BITS(DW), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy),
        .state       (state)
    );

    // ---------------- clock / tick / ready generation ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tick_div  = (tick_div == TICK_CLKS - 1) ? 0 : tick_div + 1;
        baud_tick = (tick_div == 0);
        case (rdy_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid)    vcyc++;
            if (frame_err)   fe_cnt++;
            if (overrun_err) ov_cnt++;
            if (rx_valid && rx_ready) begin
                logic [DW-1:0] exp;
                rx_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_byte: got %02h, expected none", rx_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (rx_data !== exp) begin
                        n_errors++;
                        $display("FAIL rx_byte: got %02h, expected %02h", rx_data, exp);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input int bc);
        rx = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            wait_clks(bc);
        end
        rx = stop_bit;
        wait_clks(bc);
    endtask

    task automatic send_good(input logic [DW-1:0] d, input int bc);
        exp_q.push_back(d);
        n_sent++;
        send_frame(d, 1'b1, bc);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] b;
        logic [DW-1:0] f0;
        int            rx_before;
        int            v_before;
        int            bc_tab[3];

        #2 reset = 1'b0;
        wait_clks(5);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun_err", 32'(overrun_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(state), 32'(IDLE));
        reset = 1'b1;
        wait_clks(5);
        rdy_mode = 1;
        wait_clks(3);

        // Single frame, consumer always ready
        v_before = vcyc;
        send_good(8'h55, BIT_CLKS);
        wait_drain("t1_drain");
        @(negedge clk);
        check("t1_valid_low", 32'(rx_valid), 32'd0);
        check("t1_valid_cycles", 32'(vcyc - v_before), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_frame_err", 32'(fe_cnt), 32'd0);
        wait_clks(1);

        // Short low glitch must be rejected silently
        rx_before = rx_cnt;
        rx = 1'b0;
        wait_clks(3 * TICK_CLKS);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("t2_no_byte", 32'(rx_cnt), 32'(rx_before));
        check("t2_no_frame_err", 32'(fe_cnt), 32'd0);
        check("t2_state", 32'(state), 32'(IDLE));
        check("t2_busy", 32'(busy), 32'd0);

        // Bad stop bit then a long break: one frame_err only
        send_frame(8'hA3, 1'b0, BIT_CLKS);
        wait_clks(20 * BIT_CLKS);
        check("t3_frame_err_once", 32'(fe_cnt), 32'd1);
        check("t3_no_byte", 32'(rx_cnt), 32'(rx_before));
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        send_good(8'h3C, BIT_CLKS);
        wait_drain("t3_drain");
        check("t3_frame_err_total", 32'(fe_cnt), 32'd1);

        // Overrun: second byte dropped while first is held
        rdy_mode = 0;
        wait_clks(2);
        send_good(8'h11, BIT_CLKS);
        send_frame(8'h22, 1'b1, BIT_CLKS);
        wait_clks(BIT_CLKS);
        check("t4_overrun_once", 32'(ov_cnt), 32'd1);
        check("t4_held_valid", 32'(rx_valid), 32'd1);
        check("t4_held_data", 32'(rx_data), 32'h11);
        rdy_mode = 1;
        wait_drain("t4_drain_first");
        send_good(8'h33, BIT_CLKS);
        wait_drain("t4_drain_second");
        check("t4_no_new_overrun", 32'(ov_cnt), 32'd1);

        // Reset in the middle of bit 4
        f0 = 8'hF0;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = f0[i];
            wait_clks(BIT_CLKS);
        end
        rx = f0[4];
        wait_clks(BIT_CLKS / 2);
        reset = 1'b0;
        #1;
        check("t5_rx_data", 32'(rx_data), 32'd0);
        check("t5_rx_valid", 32'(rx_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_frame_err", 32'(frame_err), 32'd0);
        check("t5_overrun_err", 32'(overrun_err), 32'd0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        reset = 1'b1;
        wait_clks(4);
        send_good(8'hF0, BIT_CLKS);
        wait_drain("t5_drain");
        check("t5_no_flags_fe", 32'(fe_cnt), 32'd1);
        check("t5_no_flags_ov", 32'(ov_cnt), 32'd1);

        // Back-to-back frames at nominal and +/-3% line rate
        bc_tab[0] = BIT_CLKS;
        bc_tab[1] = BIT_CLKS - 4;
        bc_tab[2] = BIT_CLKS + 4;
        for (int k = 0; k < 3; k++) begin
            send_good(8'h00, bc_tab[k]);
            send_good(8'hFF, bc_tab[k]);
            send_good(8'h5A, bc_tab[k]);
            wait_drain("t6_drain");
            check("t6_frame_err", 32'(fe_cnt), 32'd1);
            check("t6_overrun", 32'(ov_cnt), 32'd1);
            wait_clks(BIT_CLKS);
        end

        // Random bytes, random rate skew, random gaps, bursty consumer
        rdy_mode = 2;
        for (int k = 0; k < 12; k++) begin
            b = DW'($urandom_range(0, 255));
            send_good(b, $urandom_range(BIT_CLKS - 4, BIT_CLKS + 4));
            wait_clks($urandom_range(0, BIT_CLKS));
        end
        wait_drain("rand_drain");
        check("rand_frame_err", 32'(fe_cnt), 32'd1);
        check("rand_overrun", 32'(ov_cnt), 32'd1);
        check("total_bytes", 32'(rx_cnt), 32'(n_sent));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
